// File: rtl/odyssey_timing_ctrl.sv
// Odyssey video timing generator: h/v counters, sync/blank/de decode, line/frame
// strobes and a frame-synchronous latch of the analog controller inputs.
// Define ODYSSEY_PAL_TIMING_EN for 312-line PAL frames (default: 262-line NTSC).
`timescale 1ns/1ps

module odyssey_timing_ctrl #(
  parameter int H_TOTAL  = 1270,
  parameter int H_SYNC   = 94,
  parameter int H_BACK   = 114,
  parameter int H_ACTIVE = 1040,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [63:0] analog_in,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        HSync,
  output logic        VSync,
  output logic        HBlank,
  output logic        VBlank,
  output logic        de,
  output logic        line_start,
  output logic        frame_start,
  output logic [63:0] analog_latched,
  output logic        latched_valid
);

`ifdef ODYSSEY_PAL_TIMING_EN
  localparam int V_TOTAL  = 312;
  localparam int V_ACTIVE = 288;
`else
  localparam int V_TOTAL  = 262;
  localparam int V_ACTIVE = 240;
`endif

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_SYNC_END = 11'(H_SYNC);
  localparam logic [10:0] H_ACT_BEG  = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_ACT_END  = 11'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [10:0] V_SYNC_END = 11'(V_SYNC);
  localparam logic [10:0] V_ACT_BEG  = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_ACT_END  = 11'(V_SYNC + V_BACK + V_ACTIVE);

  function automatic logic in_window(input logic [10:0] pos,
                                     input logic [10:0] lo,
                                     input logic [10:0] hi);
    return (pos >= lo) && (pos < hi);
  endfunction

  logic [10:0] hcount_p0;
  logic [9:0]  vcount_p0;
  logic        h_wrap_p0;
  logic        v_wrap_p0;
  logic        hsync_p0;
  logic        vsync_p0;
  logic        h_act_p0;
  logic        v_act_p0;

  // Stage p0: next counter values and their decodes, so registered decodes
  // line up with the registered counters in the same cycle.
  always_comb begin
    h_wrap_p0 = ce && (hcount == H_LAST);
    v_wrap_p0 = h_wrap_p0 && (vcount == V_LAST);
    hcount_p0 = hcount;
    vcount_p0 = vcount;
    if (ce) begin
      if (h_wrap_p0) begin
        hcount_p0 = '0;
        vcount_p0 = v_wrap_p0 ? '0 : vcount + 10'd1;
      end else begin
        hcount_p0 = hcount + 11'd1;
      end
    end
    hsync_p0 = hcount_p0 < H_SYNC_END;
    vsync_p0 = {1'b0, vcount_p0} < V_SYNC_END;
    h_act_p0 = in_window(hcount_p0, H_ACT_BEG, H_ACT_END);
    v_act_p0 = in_window({1'b0, vcount_p0}, V_ACT_BEG, V_ACT_END);
  end

  // Stage p1: output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      hcount         <= '0;
      vcount         <= '0;
      HSync          <= 1'b1;
      VSync          <= 1'b1;
      HBlank         <= 1'b1;
      VBlank         <= 1'b1;
      de             <= 1'b0;
      line_start     <= 1'b0;
      frame_start    <= 1'b0;
      analog_latched <= '0;
      latched_valid  <= 1'b0;
    end else begin
      hcount      <= hcount_p0;
      vcount      <= vcount_p0;
      HSync       <= hsync_p0;
      VSync       <= vsync_p0;
      HBlank      <= ~h_act_p0;
      VBlank      <= ~v_act_p0;
      de          <= h_act_p0 & v_act_p0;
      line_start  <= h_wrap_p0;
      frame_start <= v_wrap_p0;
      // Capture only at the last cycle of a frame so the copy appears with frame_start.
      if (v_wrap_p0) begin
        analog_latched <= analog_in;
        latched_valid  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_odyssey_timing_ctrl.sv
// Directed bench for odyssey_timing_ctrl: a default-parameter instance for line
// timing and a short-line instance (H_TOTAL=40) for frame-level behaviour.
`timescale 1ns/1ps

module tb_odyssey_timing_ctrl;

`ifdef ODYSSEY_PAL_TIMING_EN
  localparam int VT = 312;
  localparam int VA = 288;
`else
  localparam int VT = 262;
  localparam int VA = 240;
`endif
  localparam int SH = 40;          // short-line instance H_TOTAL
  localparam int FR = SH * VT;     // short-line frame length in cycles

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic [63:0] analog_in;

  logic [10:0] d_hcount, s_hcount;
  logic [9:0]  d_vcount, s_vcount;
  logic        d_hsync, d_vsync, d_hblank, d_vblank, d_de, d_ls, d_fs, d_valid;
  logic        s_hsync, s_vsync, s_hblank, s_vblank, s_de, s_ls, s_fs, s_valid;
  logic [63:0] d_latched, s_latched;

  int n_checks = 0;
  int n_fail   = 0;
  int c;
  int fs_seen;

  always #5 clk = ~clk;

  odyssey_timing_ctrl u_dut (
    .clk(clk), .reset(reset), .ce(ce), .analog_in(analog_in),
    .hcount(d_hcount), .vcount(d_vcount), .HSync(d_hsync), .VSync(d_vsync),
    .HBlank(d_hblank), .VBlank(d_vblank), .de(d_de), .line_start(d_ls),
    .frame_start(d_fs), .analog_latched(d_latched), .latched_valid(d_valid)
  );

  odyssey_timing_ctrl #(.H_TOTAL(SH), .H_SYNC(4), .H_BACK(6), .H_ACTIVE(24)) u_sm (
    .clk(clk), .reset(reset), .ce(ce), .analog_in(analog_in),
    .hcount(s_hcount), .vcount(s_vcount), .HSync(s_hsync), .VSync(s_vsync),
    .HBlank(s_hblank), .VBlank(s_vblank), .de(s_de), .line_start(s_ls),
    .frame_start(s_fs), .analog_latched(s_latched), .latched_valid(s_valid)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance the short-line timeline (cycles since reset release) to target.
  task automatic to_c(input int target);
    tick(target - c);
    c = target;
  endtask

  task automatic check_sm_reset(input string tag);
    check({tag, ".hcount"}, 64'(s_hcount), 64'd0);
    check({tag, ".vcount"}, 64'(s_vcount), 64'd0);
    check({tag, ".HSync"},  64'(s_hsync),  64'd1);
    check({tag, ".VSync"},  64'(s_vsync),  64'd1);
    check({tag, ".HBlank"}, 64'(s_hblank), 64'd1);
    check({tag, ".VBlank"}, 64'(s_vblank), 64'd1);
    check({tag, ".de"},     64'(s_de),     64'd0);
    check({tag, ".ls"},     64'(s_ls),     64'd0);
    check({tag, ".fs"},     64'(s_fs),     64'd0);
    check({tag, ".latch"},  s_latched,     64'd0);
    check({tag, ".valid"},  64'(s_valid),  64'd0);
  endtask

  initial begin
    reset = 1'b1;
    ce = 1'b0;
    analog_in = 64'h5555_AAAA_5555_AAAA;
    tick(3);

    // Reset state on the default-parameter instance
    check("rst.hcount", 64'(d_hcount), 64'd0);
    check("rst.vcount", 64'(d_vcount), 64'd0);
    check("rst.HSync",  64'(d_hsync),  64'd1);
    check("rst.VSync",  64'(d_vsync),  64'd1);
    check("rst.HBlank", 64'(d_hblank), 64'd1);
    check("rst.VBlank", 64'(d_vblank), 64'd1);
    check("rst.de",     64'(d_de),     64'd0);
    check("rst.strobes", 64'({d_ls, d_fs}), 64'd0);
    check("rst.latch",  d_latched,     64'd0);
    check("rst.valid",  64'(d_valid),  64'd0);
    ce = 1'b1;
    tick(1);
    check("rst_over_ce.hcount", 64'(d_hcount), 64'd0);

    // Line timing, default parameters
    reset = 1'b0;
    tick(1);
    check("run.h1", 64'(d_hcount), 64'd1);
    tick(92);
    check("h93.HSync", 64'(d_hsync), 64'd1);
    tick(1);
    check("h94.hcount", 64'(d_hcount), 64'd94);
    check("h94.HSync",  64'(d_hsync),  64'd0);
    tick(113);
    check("h207.HBlank", 64'(d_hblank), 64'd1);
    tick(1);
    check("h208.HBlank", 64'(d_hblank), 64'd0);
    check("h208.de_vblank", 64'(d_de), 64'd0);
    tick(1039);
    check("h1247.HBlank", 64'(d_hblank), 64'd0);
    tick(1);
    check("h1248.HBlank", 64'(d_hblank), 64'd1);
    tick(21);
    check("h1269.hcount", 64'(d_hcount), 64'd1269);
    check("h1269.ls", 64'(d_ls), 64'd0);
    tick(1);
    check("wrap1.hcount", 64'(d_hcount), 64'd0);
    check("wrap1.vcount", 64'(d_vcount), 64'd1);
    check("wrap1.ls", 64'(d_ls), 64'd1);
    check("wrap1.fs", 64'(d_fs), 64'd0);
    check("wrap1.HSync", 64'(d_hsync), 64'd1);
    tick(1);
    check("wrap1+1.ls", 64'(d_ls), 64'd0);
    tick(1269);
    check("wrap2.ls", 64'(d_ls), 64'd1);
    check("wrap2.vcount", 64'(d_vcount), 64'd2);

    // Frame-level behaviour on the short-line instance
    reset = 1'b1;
    analog_in = 64'd0;
    tick(2);
    check_sm_reset("sm_rst");
    reset = 1'b0;
    c = 0;
    to_c(1);
    check("sm.h1", 64'(s_hcount), 64'd1);
    to_c(3);
    check("sm.h3.HSync", 64'(s_hsync), 64'd1);
    to_c(4);
    check("sm.h4.HSync", 64'(s_hsync), 64'd0);
    to_c(2 * SH + 20);
    check("v2.VSync", 64'(s_vsync), 64'd1);
    to_c(3 * SH + 20);
    check("v3.VSync", 64'(s_vsync), 64'd0);
    to_c(18 * SH + 20);
    check("v18.VBlank", 64'(s_vblank), 64'd1);
    check("v18.de", 64'(s_de), 64'd0);
    to_c(19 * SH + 20);
    check("v19.VBlank", 64'(s_vblank), 64'd0);
    check("v19.de", 64'(s_de), 64'd1);
    to_c(19 * SH + 34);
    check("v19.h34.de", 64'(s_de), 64'd0);
    to_c(1000);
    analog_in = 64'h0123456789ABCDEF;
    to_c((19 + VA - 1) * SH + 20);
    check("vlast_act.de", 64'(s_de), 64'd1);
    to_c((19 + VA) * SH + 20);
    check("vpost_act.de", 64'(s_de), 64'd0);
    check("vpost_act.VBlank", 64'(s_vblank), 64'd1);
    to_c(FR - 1);
    check("pre_frame.hcount", 64'(s_hcount), 64'(SH - 1));
    check("pre_frame.vcount", 64'(s_vcount), 64'(VT - 1));
    check("pre_frame.latch", s_latched, 64'd0);
    check("pre_frame.valid", 64'(s_valid), 64'd0);
    check("pre_frame.fs", 64'(s_fs), 64'd0);
    to_c(FR);
    check("frame1.fs", 64'(s_fs), 64'd1);
    check("frame1.ls", 64'(s_ls), 64'd1);
    check("frame1.vcount", 64'(s_vcount), 64'd0);
    check("frame1.latch", s_latched, 64'h0123456789ABCDEF);
    check("frame1.valid", 64'(s_valid), 64'd1);
    to_c(FR + 1);
    check("frame1+1.fs", 64'(s_fs), 64'd0);
    to_c(FR + 5000);
    analog_in = 64'hFEDCBA9876543210;
    check("midframe.latch", s_latched, 64'h0123456789ABCDEF);

    // Stall with ce=0 at the last cycle of the frame
    to_c(2 * FR - 1);
    ce = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      check("stall.hcount", 64'(s_hcount), 64'(SH - 1));
      check("stall.vcount", 64'(s_vcount), 64'(VT - 1));
      check("stall.strobes", 64'({s_ls, s_fs}), 64'd0);
      check("stall.latch", s_latched, 64'h0123456789ABCDEF);
      check("stall.HBlank", 64'(s_hblank), 64'd1);
    end
    ce = 1'b1;
    to_c(2 * FR);
    check("resume.fs", 64'(s_fs), 64'd1);
    check("resume.ls", 64'(s_ls), 64'd1);
    check("resume.hcount", 64'(s_hcount), 64'd0);
    check("resume.latch", s_latched, 64'hFEDCBA9876543210);

    // Reset in mid-frame at line 100
    to_c(2 * FR + 100 * SH + 5);
    check("mid.vcount", 64'(s_vcount), 64'd100);
    check("mid.hcount", 64'(s_hcount), 64'd5);
    reset = 1'b1;
    tick(1);
    check_sm_reset("mid_rst");
    reset = 1'b0;
    tick(1);
    check("post_rst.hcount", 64'(s_hcount), 64'd1);
    fs_seen = 0;
    for (int i = 0; i < FR - 2; i++) begin
      tick(1);
      if (s_fs === 1'b1) fs_seen++;
    end
    check("post_rst.no_fs", 64'(fs_seen), 64'd0);
    tick(1);
    check("post_rst.first_fs", 64'(s_fs), 64'd1);
    check("post_rst.latch", s_latched, 64'hFEDCBA9876543210);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/odyssey_timing_ctrl.md
ODYSSEY_TIMING_CTRL -- requirements
Module: odyssey_timing_ctrl

Interface
REQ-001 SHALL have parameter H_TOTAL, default 1270, meaning clk_sys cycles per line (63.5 us at 20 MHz).
REQ-002 SHALL have parameter H_SYNC, default 94, meaning HSync width in cycles.
REQ-003 SHALL have parameter H_BACK, default 114, meaning back-porch cycles after HSync.
REQ-004 SHALL have parameter H_ACTIVE, default 1040, meaning visible cycles per line; front porch = H_TOTAL-H_SYNC-H_BACK-H_ACTIVE (22).
REQ-005 SHALL have parameter V_SYNC, default 3, meaning VSync width in lines.
REQ-006 SHALL have parameter V_BACK, default 16, meaning back-porch lines.
REQ-007 SHALL have port clk, input, 1, meaning system clock (clk_sys, 20 MHz).
REQ-008 SHALL have port reset, input, 1, meaning synchronous, active-high reset.
REQ-009 SHALL have port ce, input, 1, meaning advance enable; counters hold while low.
REQ-010 SHALL have port analog_in, input, 64, meaning {P2 R Y,X, P2 L Y,X, P1 R Y,X, P1 L Y,X}, 8 bits each, unsynchronised to frame.
REQ-011 SHALL have port hcount, output, 11, meaning horizontal position.
REQ-012 SHALL have port vcount, output, 10, meaning line number.
REQ-013 SHALL have ports HSync, VSync, HBlank, VBlank, de, output, 1 each, meaning active-high sync, blanking and display enable.
REQ-014 SHALL have ports line_start, frame_start, output, 1 each, meaning single-cycle strobes.
REQ-015 SHALL have port analog_latched, output, 64, meaning frame-stable copy of analog_in.
REQ-016 SHALL have port latched_valid, output, 1, meaning analog_latched holds at least one captured sample.

Function
REQ-017 SHALL, when ce=1, increment hcount; at H_TOTAL-1 SHALL wrap hcount to 0 and increment vcount; at V_TOTAL-1 with hcount wrapping SHALL wrap vcount to 0.
REQ-018 SHALL hold hcount, vcount and all level outputs while ce=0; strobes SHALL be 0 while ce=0.
REQ-019 SHALL register all outputs; level outputs SHALL decode the hcount/vcount presented in the same cycle (zero skew between counters and decodes).
REQ-020 SHALL drive HSync=1 iff hcount<H_SYNC; VSync=1 iff vcount<V_SYNC.
REQ-021 SHALL drive HBlank=0 iff H_SYNC+H_BACK <= hcount < H_SYNC+H_BACK+H_ACTIVE; VBlank=0 iff V_SYNC+V_BACK <= vcount < V_SYNC+V_BACK+V_ACTIVE.
REQ-022 SHALL drive de = ~HBlank & ~VBlank.
REQ-023 SHALL pulse line_start for one cycle when hcount transitions to 0 by wrap; frame_start additionally when vcount also transitions to 0.
REQ-024 SHALL copy analog_in into analog_latched on the ce=1 cycle where hcount=H_TOTAL-1 and vcount=V_TOTAL-1, so the new value is visible with frame_start; latched_valid SHALL set on that cycle and stay set.
REQ-025 SHALL never change analog_latched at any other time, including while ce=0.

Reset
REQ-026 SHALL, while reset=1 (overriding ce), set hcount=0, vcount=0, HSync=1, VSync=1, HBlank=1, VBlank=1, de=0, line_start=0, frame_start=0, analog_latched=0, latched_valid=0.
REQ-027 SHALL, on reset mid-frame, abandon the frame immediately; no strobe SHALL be emitted for the reset-induced return to (0,0); first frame_start follows one full frame after release.

Configuration
REQ-028 SHALL, with macro ODYSSEY_PAL_TIMING_EN defined, use V_TOTAL=312 and V_ACTIVE=288.
REQ-029 SHALL, without ODYSSEY_PAL_TIMING_EN, use V_TOTAL=262 and V_ACTIVE=240.

Verification
REQ-030 SHALL cover: reset released, ce=1 held -> hcount 0..1269, line_start every 1270 cycles, frame_start every 332740 cycles (396240 with ODYSSEY_PAL_TIMING_EN).
REQ-031 SHALL cover: decode at hcount=93/94, 207/208, 1247/1248 -> HSync 1->0 at 94, HBlank 1->0 at 208, 0->1 at 1248; de=1 only for vcount 19..258.
REQ-032 SHALL cover: analog_in changed to 64'h0123456789ABCDEF mid-frame -> analog_latched unchanged until frame_start cycle, then equal; latched_valid 0->1 at first frame boundary.
REQ-033 SHALL cover: ce=0 for 50 cycles at hcount=1269, vcount=261 -> all outputs frozen, no strobe; strobes and latch fire on first ce=1 cycle.
REQ-034 SHALL cover: reset asserted at vcount=100 -> next cycle reset values per REQ-026; no frame_start until 332740 cycles after release.
